mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multi-cycle MIPS main control FSM; the producer side of the ALU interface. Decodes
//  Op/Funct from the IR, sequences FETCH/DECODE/EXEC/MEM/WB, drives ALUOp, operand
//  selects and write enables, and uses the ALU Zero flag to resolve beq/bne.
//  Sits between the IR and the datapath muxes, PC, RF, DM and ALU.
// PARAMETERS
//  RESET_STATE  4'd0  state entered on rst (S_FETCH)
// PORTS
//  clk      in   1  single system clock, rising edge
//  rst      in   1  asynchronous, active-high reset
//  Op       in   6  IR[31:26]
//  Funct    in   6  IR[5:0]
//  Zero     in   1  ALU result==0, valid in S_BRANCH
//  PCWrite  out  1  PC load enable
//  IRWrite  out  1  IR load enable
//  RegWrite out  1  RF write enable
//  MemWrite out  1  DM write enable
//  IorD     out  1  0: DM addr=PC, 1: DM addr=ALUOut
//  EXTOp    out  1  1: sign-extend imm16, 0: zero-extend
//  ALUOp    out  4  ALU_* code from ctrl_encode_def.v
//  ALUSrcA  out  2  0: PC, 1: rs, 2: {27'b0,shamt}
//  ALUSrcB  out  2  0: rt, 1: const 4, 2: ext imm
//  NPCOp    out  2  0: ALU (PC+4), 1: branch, 2: jump, 3: jr(rs)
//  GPRSel   out  2  0: rd, 1: rt, 2: $31
//  WDSel    out  2  0: ALUOut, 1: MDR, 2: PC
//  state_o  out  4  current state, debug/verification
// BEHAVIOUR
//  - State reg: posedge clk; rst -> RESET_STATE immediately. Moore outputs from
//    state + Op/Funct. While rst=1, all write enables (PC/IR/Reg/Mem) forced 0.
//  - Default every cycle: enables 0, ALUOp=ALU_NOP, selects 0.
//  - S_FETCH(0): IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUOp=ALU_ADD, NPCOp=0,
//    PCWrite=1 -> S_DCODE.
//  - S_DCODE(1): no writes. lw/sw->S_MADR; R-type (jr excluded), addi/andi/ori/slti/
//    lui->S_EXE; beq/bne->S_BRANCH; j/jal/jr->S_JMP; undefined Op/Funct->S_FETCH.
//  - S_MADR(2): ALUSrcA=1, ALUSrcB=2, EXTOp=1, ALU_ADD; lw->S_MLD, sw->S_MST.
//  - S_MLD(3): IorD=1 -> S_MLDWB(4): RegWrite=1, GPRSel=1, WDSel=1 -> S_FETCH.
//  - S_MST(5): IorD=1, MemWrite=1 -> S_FETCH.
//  - S_EXE(6): R: ALUSrcA=1 (sll/srl: 2), ALUSrcB=0, ALUOp from Funct;
//    I: ALUSrcA=1, ALUSrcB=2, EXTOp=1 for addi/slti, 0 for andi/ori/lui -> S_ALUWB.
//  - S_ALUWB(7): RegWrite=1, WDSel=0, GPRSel=0 (R) / 1 (I); ALUOp held -> S_FETCH.
//  - S_BRANCH(8): ALUSrcA=1, ALUSrcB=0, ALU_SUB, NPCOp=1, EXTOp=1;
//    PCWrite = beq ? Zero : ~Zero -> S_FETCH.
//  - S_JMP(9): PCWrite=1; j/jal NPCOp=2, jr NPCOp=3; jal: RegWrite=1, GPRSel=2, WDSel=2
//    -> S_FETCH.
//  - Latency: lw 5, sw/R/I 4, branch/jump 3 cycles. States 10..15 -> S_FETCH, no writes.
//  - Funct map: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT,
//    101011 SLTU, 100111 NOR, 000000 SLL, 000010 SRL. Op map: 001000 ADD, 001100 AND,
//    001101 OR, 001010 SLT, 001111 LUI.
//  - rst mid-instruction: abandons it; first post-reset cycle is S_FETCH, no partial write.
// STRUCTURE
//  - ctrl_encode_def.v gains: S_* state codes, NPC_*, WD_*, GPR_*, SRCA_*/SRCB_* codes,
//    OP_*/FUNCT_* opcodes. ALU_* codes are reused unchanged.
//  - Sub-module mc_ctrl_decode (combinational): Op/Funct -> instr class + ALUOp + EXTOp.
//    FSM stays in mc_ctrl_fsm.
// TESTING
//  1 rst=1 mid-S_MLD, release -> state_o=0, write enables 0 while rst=1; next edge ->
//    state_o=1.
//  2 lw (Op=100011) -> states 0,1,2,3,4,0; RegWrite=1 only in 4 with GPRSel=1, WDSel=1.
//  3 add (Op=0, Funct=100000) -> 0,1,6,7,0; ALUOp=ALU_ADD in 6 and 7; RegWrite only in 7.
//    sll: ALUSrcA=2 in 6.
//  4 beq with Zero=1 -> PCWrite=1 in state 8; Zero=0 -> 0. bne gives the inverse.
//  5 jal (Op=000011) -> state 9: PCWrite=1, NPCOp=2, RegWrite=1, GPRSel=2, WDSel=2.
//    jr (Funct=001000) -> NPCOp=3, RegWrite=0.
//  6 undefined Op=111111 -> 0,1,0; no PCWrite/RegWrite/MemWrite after S_FETCH.

Source files
------------

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM.
// Holds the state codes, ALU operation codes, datapath mux select codes,
// opcode/funct values and the instruction classes produced by the decoder.
package mc_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DCODE  = 4'd1,
        S_MADR   = 4'd2,
        S_MLD    = 4'd3,
        S_MLDWB  = 4'd4,
        S_MST    = 4'd5,
        S_EXE    = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JMP    = 4'd9
    } state_e;

    typedef enum logic [3:0] {
        CLS_UNDEF,
        CLS_LW,
        CLS_SW,
        CLS_RTYPE,
        CLS_ITYPE,
        CLS_BEQ,
        CLS_BNE,
        CLS_J,
        CLS_JAL,
        CLS_JR
    } instr_cls_e;

    // ALU operation codes
    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    localparam logic [1:0] NPC_PLUS4  = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_JR     = 2'd3;

    localparam logic [1:0] WD_ALUOUT = 2'd0;
    localparam logic [1:0] WD_MDR    = 2'd1;
    localparam logic [1:0] WD_PC     = 2'd2;

    localparam logic [1:0] GPR_RD  = 2'd0;
    localparam logic [1:0] GPR_RT  = 2'd1;
    localparam logic [1:0] GPR_31  = 2'd2;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_RS    = 2'd1;
    localparam logic [1:0] SRCA_SHAMT = 2'd2;

    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder for the multi-cycle control FSM.
// Ports:
//   op     in   6  IR[31:26]
//   funct  in   6  IR[5:0]
//   cls    out     instruction class (CLS_UNDEF for anything not supported)
//   alu_op out  4  ALU operation used in S_EXE / S_ALUWB
//   ext_op out  1  1: sign-extend imm16, 0: zero-extend
//   shift  out  1  R-type shift by shamt (sll/srl)
module mc_ctrl_decode
    import mc_ctrl_fsm_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output instr_cls_e cls,
    output logic [3:0] alu_op,
    output logic       ext_op,
    output logic       shift
);

    always_comb begin
        cls    = CLS_UNDEF;
        alu_op = ALU_NOP;
        ext_op = 1'b0;
        shift  = 1'b0;
        unique case (op)
            OP_RTYPE: begin
                cls = CLS_RTYPE;
                unique case (funct)
                    FUNCT_ADD:  alu_op = ALU_ADD;
                    FUNCT_SUB:  alu_op = ALU_SUB;
                    FUNCT_AND:  alu_op = ALU_AND;
                    FUNCT_OR:   alu_op = ALU_OR;
                    FUNCT_SLT:  alu_op = ALU_SLT;
                    FUNCT_SLTU: alu_op = ALU_SLTU;
                    FUNCT_NOR:  alu_op = ALU_NOR;
                    FUNCT_SLL: begin
                        alu_op = ALU_SLL;
                        shift  = 1'b1;
                    end
                    FUNCT_SRL: begin
                        alu_op = ALU_SRL;
                        shift  = 1'b1;
                    end
                    FUNCT_JR:  cls = CLS_JR;
                    default:   cls = CLS_UNDEF;
                endcase
            end
            OP_LW:   begin cls = CLS_LW; ext_op = 1'b1; alu_op = ALU_ADD; end
            OP_SW:   begin cls = CLS_SW; ext_op = 1'b1; alu_op = ALU_ADD; end
            OP_ADDI: begin cls = CLS_ITYPE; alu_op = ALU_ADD; ext_op = 1'b1; end
            OP_SLTI: begin cls = CLS_ITYPE; alu_op = ALU_SLT; ext_op = 1'b1; end
            OP_ANDI: begin cls = CLS_ITYPE; alu_op = ALU_AND; end
            OP_ORI:  begin cls = CLS_ITYPE; alu_op = ALU_OR;  end
            OP_LUI:  begin cls = CLS_ITYPE; alu_op = ALU_LUI; end
            OP_BEQ:  cls = CLS_BEQ;
            OP_BNE:  cls = CLS_BNE;
            OP_J:    cls = CLS_J;
            OP_JAL:  cls = CLS_JAL;
            default: cls = CLS_UNDEF;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main control FSM (producer side of the ALU interface).
// Sequences FETCH/DECODE/EXEC/MEM/WB and drives the datapath controls.
// Ports:
//   clk, rst (async, active high)
//   Op, Funct (from IR), Zero (ALU result == 0, used in S_BRANCH)
//   PCWrite, IRWrite, RegWrite, MemWrite  write enables (held 0 while rst=1)
//   IorD, EXTOp, ALUOp, ALUSrcA, ALUSrcB, NPCOp, GPRSel, WDSel  datapath selects
//   state_o  current state for debug
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IorD,
    output logic       EXTOp,
    output logic [3:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] NPCOp,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic [3:0] state_o
);

    state_e     state, state_nxt;
    instr_cls_e cls;
    logic [3:0] dec_alu_op;
    logic       dec_ext_op, dec_shift;
    logic       pc_write, ir_write, reg_write, mem_write;

    mc_ctrl_decode u_decode (
        .op     (Op),
        .funct  (Funct),
        .cls    (cls),
        .alu_op (dec_alu_op),
        .ext_op (dec_ext_op),
        .shift  (dec_shift)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= state_e'(RESET_STATE);
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_FETCH;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        IorD      = 1'b0;
        EXTOp     = 1'b0;
        ALUOp     = ALU_NOP;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RT;
        NPCOp     = NPC_PLUS4;
        GPRSel    = GPR_RD;
        WDSel     = WD_ALUOUT;
        unique case (state)
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ALUOp     = ALU_ADD;
                state_nxt = S_DCODE;
            end
            S_DCODE: begin
                unique case (cls)
                    CLS_LW, CLS_SW:          state_nxt = S_MADR;
                    CLS_RTYPE, CLS_ITYPE:    state_nxt = S_EXE;
                    CLS_BEQ, CLS_BNE:        state_nxt = S_BRANCH;
                    CLS_J, CLS_JAL, CLS_JR:  state_nxt = S_JMP;
                    default:                 state_nxt = S_FETCH;
                endcase
            end
            S_MADR: begin
                ALUSrcA = SRCA_RS;
                ALUSrcB = SRCB_IMM;
                EXTOp   = 1'b1;
                ALUOp   = ALU_ADD;
                if (cls == CLS_LW)      state_nxt = S_MLD;
                else if (cls == CLS_SW) state_nxt = S_MST;
            end
            S_MLD: begin
                IorD      = 1'b1;
                state_nxt = S_MLDWB;
            end
            S_MLDWB: begin
                reg_write = 1'b1;
                GPRSel    = GPR_RT;
                WDSel     = WD_MDR;
            end
            S_MST: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXE: begin
                ALUOp = dec_alu_op;
                if (cls == CLS_RTYPE) begin
                    ALUSrcA = dec_shift ? SRCA_SHAMT : SRCA_RS;
                    ALUSrcB = SRCB_RT;
                end else begin
                    ALUSrcA = SRCA_RS;
                    ALUSrcB = SRCB_IMM;
                    EXTOp   = dec_ext_op;
                end
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                // ALUOp held so ALUOut stays stable while it is written back
                reg_write = 1'b1;
                ALUOp     = dec_alu_op;
                GPRSel    = (cls == CLS_RTYPE) ? GPR_RD : GPR_RT;
            end
            S_BRANCH: begin
                ALUSrcA  = SRCA_RS;
                ALUSrcB  = SRCB_RT;
                ALUOp    = ALU_SUB;
                NPCOp    = NPC_BRANCH;
                EXTOp    = 1'b1;
                pc_write = (cls == CLS_BNE) ? ~Zero : Zero;
            end
            S_JMP: begin
                pc_write = 1'b1;
                NPCOp    = (cls == CLS_JR) ? NPC_JR : NPC_JUMP;
                if (cls == CLS_JAL) begin
                    reg_write = 1'b1;
                    GPRSel    = GPR_31;
                    WDSel     = WD_PC;
                end
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Reset puts the state in S_FETCH asynchronously; gate enables so no
    // write happens while rst is still asserted.
    assign PCWrite  = pc_write & ~rst;
    assign IRWrite  = ir_write & ~rst;
    assign RegWrite = reg_write & ~rst;
    assign MemWrite = mem_write & ~rst;
    assign state_o  = state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed instructions, a mid-instruction
// reset, then random instructions checked against a per-instruction cycle model.
module tb_mc_ctrl_fsm;

    localparam logic [3:0] A_NOP = 4'd0, A_ADD = 4'd1, A_SUB = 4'd2, A_AND = 4'd3,
                           A_OR = 4'd4, A_SLT = 4'd5, A_SLTU = 4'd6, A_NOR = 4'd7,
                           A_SLL = 4'd8, A_SRL = 4'd9, A_LUI = 4'd10;

    localparam int K_UNDEF = 0, K_LW = 1, K_SW = 2, K_R = 3, K_I = 4, K_BEQ = 5,
                   K_BNE = 6, K_J = 7, K_JAL = 8, K_JR = 9;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, irw, rw, mw, iord, ext;
        logic [3:0] alu;
        logic [1:0] sa, sb, npc, gpr, wd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op, Funct;
    logic       Zero;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, IorD, EXTOp;
    logic [3:0] ALUOp, state_o;
    logic [1:0] ALUSrcA, ALUSrcB, NPCOp, GPRSel, WDSel;

    int checks = 0;
    int errors = 0;

    mc_ctrl_fsm dut (
        .clk      (clk),
        .rst      (rst),
        .Op       (Op),
        .Funct    (Funct),
        .Zero     (Zero),
        .PCWrite  (PCWrite),
        .IRWrite  (IRWrite),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .IorD     (IorD),
        .EXTOp    (EXTOp),
        .ALUOp    (ALUOp),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .NPCOp    (NPCOp),
        .GPRSel   (GPRSel),
        .WDSel    (WDSel),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    exp_t obs;
    assign obs = {state_o, PCWrite, IRWrite, RegWrite, MemWrite, IorD, EXTOp, ALUOp,
                  ALUSrcA, ALUSrcB, NPCOp, GPRSel, WDSel};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b001111: return K_I;
            6'b000100: return K_BEQ;
            6'b000101: return K_BNE;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            6'b000000: begin
                case (fn)
                    6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b101011,
                    6'b100111, 6'b000000, 6'b000010: return K_R;
                    6'b001000: return K_JR;
                    default:   return K_UNDEF;
                endcase
            end
            default: return K_UNDEF;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000) begin
            case (fn)
                6'b100000: return A_ADD;
                6'b100010: return A_SUB;
                6'b100100: return A_AND;
                6'b100101: return A_OR;
                6'b101010: return A_SLT;
                6'b101011: return A_SLTU;
                6'b100111: return A_NOR;
                6'b000000: return A_SLL;
                6'b000010: return A_SRL;
                default:   return A_NOP;
            endcase
        end
        case (op)
            6'b001000: return A_ADD;
            6'b001100: return A_AND;
            6'b001101: return A_OR;
            6'b001010: return A_SLT;
            6'b001111: return A_LUI;
            default:   return A_NOP;
        endcase
    endfunction

    // Cycles per instruction, FETCH included
    function automatic int len_of(input int kd);
        case (kd)
            K_LW:                         return 5;
            K_SW, K_R, K_I:               return 4;
            K_BEQ, K_BNE, K_J, K_JAL, K_JR: return 3;
            default:                      return 2;
        endcase
    endfunction

    // Expected outputs in cycle k of an instruction (k=0 is FETCH)
    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input logic z, input int k);
        exp_t e;
        int   kd;
        kd = kind_of(op, fn);
        e  = '0;
        if (k == 0) begin
            e.st = 4'd0; e.irw = 1'b1; e.pcw = 1'b1; e.sb = 2'd1; e.alu = A_ADD;
        end else if (k == 1) begin
            e.st = 4'd1;
        end else if (kd == K_LW || kd == K_SW) begin
            if (k == 2) begin
                e.st = 4'd2; e.sa = 2'd1; e.sb = 2'd2; e.ext = 1'b1; e.alu = A_ADD;
            end else if (kd == K_SW) begin
                e.st = 4'd5; e.iord = 1'b1; e.mw = 1'b1;
            end else if (k == 3) begin
                e.st = 4'd3; e.iord = 1'b1;
            end else begin
                e.st = 4'd4; e.rw = 1'b1; e.gpr = 2'd1; e.wd = 2'd1;
            end
        end else if (kd == K_R || kd == K_I) begin
            e.alu = alu_of(op, fn);
            if (k == 2) begin
                e.st = 4'd6;
                if (kd == K_R) begin
                    e.sa = (fn == 6'b000000 || fn == 6'b000010) ? 2'd2 : 2'd1;
                end else begin
                    e.sa  = 2'd1;
                    e.sb  = 2'd2;
                    e.ext = (op == 6'b001000 || op == 6'b001010);
                end
            end else begin
                e.st = 4'd7; e.rw = 1'b1; e.gpr = (kd == K_R) ? 2'd0 : 2'd1;
            end
        end else if (kd == K_BEQ || kd == K_BNE) begin
            e.st = 4'd8; e.sa = 2'd1; e.alu = A_SUB; e.npc = 2'd1; e.ext = 1'b1;
            e.pcw = (kd == K_BEQ) ? z : !z;
        end else begin
            e.st = 4'd9; e.pcw = 1'b1; e.npc = (kd == K_JR) ? 2'd3 : 2'd2;
            if (kd == K_JAL) begin
                e.rw = 1'b1; e.gpr = 2'd2; e.wd = 2'd2;
            end
        end
        return e;
    endfunction

    // Entered just after a rising edge with the DUT in FETCH; runs up to max_steps cycles
    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int max_steps);
        int n;
        Op = op; Funct = fn; Zero = z;
        n = len_of(kind_of(op, fn));
        for (int k = 0; k < n && k < max_steps; k++) begin
            @(negedge clk);
            check($sformatf("%s op=%b fn=%b z=%0b k%0d", tag, op, fn, z, k),
                  32'(obs), 32'(model(op, fn, z, k)));
            @(posedge clk);
            #1;
        end
    endtask

    logic [5:0] ops [16] = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000000,
                             6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b001010,
                             6'b001111, 6'b000100, 6'b000101, 6'b000010, 6'b000011,
                             6'b000000};
    logic [5:0] fns [16] = '{6'd0, 6'd0, 6'b100000, 6'b100010, 6'b000000, 6'b000010,
                             6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0,
                             6'b001000};

    initial begin
        rst = 1'b1; Op = '0; Funct = '0; Zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset state", 32'(state_o), 32'd0);
        check("reset enables", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        run_instr("lw", 6'b100011, 6'd0, 1'b0, 99);
        run_instr("add", 6'b000000, 6'b100000, 1'b0, 99);
        run_instr("sll", 6'b000000, 6'b000000, 1'b0, 99);
        run_instr("beq", 6'b000100, 6'd0, 1'b1, 99);
        run_instr("beq", 6'b000100, 6'd0, 1'b0, 99);
        run_instr("bne", 6'b000101, 6'd0, 1'b1, 99);
        run_instr("bne", 6'b000101, 6'd0, 1'b0, 99);
        run_instr("jal", 6'b000011, 6'd0, 1'b0, 99);
        run_instr("jr", 6'b000000, 6'b001000, 1'b0, 99);
        run_instr("sw", 6'b101011, 6'd0, 1'b0, 99);
        run_instr("lui", 6'b001111, 6'd0, 1'b0, 99);
        run_instr("undef", 6'b111111, 6'd0, 1'b0, 99);

        // Abandon a lw while it sits in S_MLD
        run_instr("lw pre-rst", 6'b100011, 6'd0, 1'b0, 3);
        #2 rst = 1'b1;
        #1;
        check("mid rst state", 32'(state_o), 32'd0);
        check("mid rst enables", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
        @(posedge clk);
        #1;
        check("rst held state", 32'(state_o), 32'd0);
        check("rst held enables", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
        #1 rst = 1'b0;
        run_instr("lw post-rst", 6'b100011, 6'd0, 1'b0, 99);

        for (int i = 0; i < 200; i++) begin
            int         idx;
            logic [5:0] op, fn;
            idx = $urandom_range(0, 15);
            op  = ops[idx];
            fn  = fns[idx];
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            run_instr("rand", op, fn, 1'($urandom), 99);
        end

        @(negedge clk);
        check("final fetch", 32'(obs), 32'(model(Op, Funct, Zero, 0)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
